host_reg_bank: RTL and testbench
================================

# host_reg_bank

Parametrised memory-mapped register bank between the 16-bit asynchronous host bus and the compute core; successor to the fixed host interface. Provides NUM_CFG configuration words, a one-cycle command pulse, a status word with sticky done/overrun flags and write-1-to-clear, a coherent multi-word result snapshot, and an interrupt output. Host strobes are synchronised and edge-detected, so each bus cycle causes exactly one register access.

## Interface
- ADDR_W, 21, host address width; bit ADDR_W-1 selects this bank when 0
- NUM_CFG, 14, number of 16-bit configuration words (1..64)
- NUM_RES, 8, number of 16-bit result words (1..64)
- CMD_W, 4, command field width (1..16)
- clk  in  1  system clock; all logic on its rising edge
- nRESET  in  1  asynchronous, active-low reset
- HOST_nCS, HOST_nWE, HOST_nOE  in  1 each  async host strobes, active low
- HOST_ADD  in  ADDR_W  byte address; bit 0 ignored
- HDI  in  16  host write data
- HDO  out  16  registered host read data
- cfg  out  NUM_CFG*16  config words; word i at cfg[16i+15:16i]
- proc_cmd  out  CMD_W  command; nonzero for exactly one cycle per command write, else 0
- proc_status  in  4  live core status
- res_din  in  NUM_RES*16  result words, word j at [16j+15:16j]
- res_valid  in  1  one-cycle pulse: res_din valid
- irq  out  1  registered interrupt, level

## Operation
- Reset: cfg, HDO, proc_cmd, irq, irq_en, last_cmd, done, overrun, result and snapshot registers all 0; synchroniser flops reset to inactive.
- wr_act = !nCS & !nWE & nOE; rd_act = !nCS & !nOE. Each passes through 2 sync flops plus 1 history flop; wr_edge / rd_edge = rising edge of the synchronised signal. HOST_ADD/HDI are sampled raw at the edge (host holds them stable for the whole strobe).
- Access requires HOST_ADD[ADDR_W-1]==0; otherwise ignored, reads return 0.
- Map (offsets in HOST_ADD[19:0]):
  - 0x00000+2i, i<NUM_CFG: cfg word i, RW.
  - 0x01000: command. Write: proc_cmd <= HDI[CMD_W-1:0] for one cycle, last_cmd <= same. Read: last_cmd zero-extended.
  - 0x02000: status, RO: [3:0] proc_status, [8] done, [9] overrun, others 0.
  - 0x02002: control, RW: [0] irq_en.
  - 0x02004: clear, WO: HDI[8]=1 clears done, HDI[9]=1 clears overrun; reads 0.
  - 0x03000+2j, j<NUM_RES: result word j, RO.
  - Anything else: writes dropped, reads 0.
- Capture: res_valid loads res_din into result regs and sets done; if done already 1, also sets overrun (data still overwritten).
- Same-cycle res_valid and clear write: set wins for both flags.
- Coherent read: read of 0x03000 copies all result regs into snapshot in the same cycle and returns word 0 from the live value; reads of words 1..NUM_RES-1 return snapshot. Capture after snapshot does not disturb snapshot.
- irq <= done & irq_en every cycle.
- Reset mid-bus-cycle: everything returns to reset values; the strobe still asserted after release produces an edge and a fresh access after the normal latency.

## Timing
- Pin strobe assertion at or before edge 0: sync1 at edge 1, sync2 at edge 2, access commits at edge 3.
- Write: cfg/control/flags update at edge 3; proc_cmd high from edge 3 to edge 4.
- Read: HDO valid after edge 3, held until next read edge; host samples no earlier than 4 clk after asserting nOE.
- Host strobe low and high times each ≥ 3 clk; shorter pulses may be lost but never produce two accesses.
- Flags/irq: res_valid at edge n -> done at edge n+1 -> irq at edge n+2.
- No back-pressure; one access per bus cycle, one capture per res_valid.

## Test plan
- Reset: assert nRESET=0 mid-cycle -> all outputs 0; write 0x1234 to 0x00000, 0xABCD to 0x0001A -> cfg word0=0x1234, word13=0xABCD, others 0; readback matches.
- Command: write 0x0002 to 0x01000 with 10-clk strobe -> proc_cmd=2 for exactly one cycle, 3 clk after assertion; read 0x01000 -> 0x0002.
- Capture/flags: res_valid with word0=0x1111 -> status=0x01xx; second res_valid -> 0x03xx; write 0x0300 to 0x02004 -> bits 8/9 = 0; clear coincident with res_valid -> done stays 1.
- Coherency: load results 0x0000..0x0007, read 0x03000, pulse res_valid with 0x00F0..0x00F7, read 0x03002 -> 0x0001 (snapshot); re-read 0x03000 then 0x03002 -> 0x00F1.
- IRQ: irq_en=0, res_valid -> irq stays 0; write 1 to 0x02002 -> irq=1 two edges later; clear done -> irq=0.
- Decode: write with HOST_ADD[20]=1 or to 0x0002E -> no register changes; reads of unmapped addresses -> 0x0000.

Source files
------------

// File: rtl/host_reg_bank.sv
// host_reg_bank: memory-mapped register bank between the 16-bit asynchronous
// host bus and the compute core.
//
// Ports:
//   clk          system clock, rising edge
//   nRESET       asynchronous active-low reset
//   HOST_nCS     host chip select (async, active low)
//   HOST_nWE     host write enable (async, active low)
//   HOST_nOE     host output enable (async, active low)
//   HOST_ADD     host byte address; top bit selects this bank when 0, bit 0 ignored
//   HDI          host write data
//   HDO          registered host read data, held until the next read access
//   cfg          NUM_CFG configuration words, word i at cfg[16i+15:16i]
//   proc_cmd     command, nonzero for exactly one cycle per command write
//   proc_status  live core status
//   res_din      NUM_RES result words, word j at res_din[16j+15:16j]
//   res_valid    single-cycle qualifier for res_din
//   irq          registered interrupt level (done & irq_en)
//
// Handshake: res_valid is a one-cycle valid with no ready; every cycle it is
// high is one capture, and the bank can always accept it.
//
// Host map (byte offsets in HOST_ADD[19:0]):
//   0x00000+2i cfg word i (RW)     0x01000 command (W pulse / R last_cmd)
//   0x02000    status (RO)         0x02002 control, bit 0 irq_en (RW)
//   0x02004    flag clear (W1C)    0x03000+2j result word j (RO)
`timescale 1ns/1ps
module host_reg_bank #(
  parameter int ADDR_W  = 21,
  parameter int NUM_CFG = 14,
  parameter int NUM_RES = 8,
  parameter int CMD_W   = 4
) (
  input  logic                    clk,
  input  logic                    nRESET,
  input  logic                    HOST_nCS,
  input  logic                    HOST_nWE,
  input  logic                    HOST_nOE,
  input  logic [ADDR_W-1:0]       HOST_ADD,
  input  logic [15:0]             HDI,
  output logic [15:0]             HDO,
  output logic [NUM_CFG*16-1:0]   cfg,
  output logic [CMD_W-1:0]        proc_cmd,
  input  logic [3:0]              proc_status,
  input  logic [NUM_RES*16-1:0]   res_din,
  input  logic                    res_valid,
  output logic                    irq
);

  localparam int CIW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int RIW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

  // Strobe synchronisers: two metastability flops plus a history flop
  logic wr_s1_q, wr_s2_q, wr_h_q;
  logic rd_s1_q, rd_s2_q, rd_h_q;
  logic wr_edge, rd_edge;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wr_s1_q <= 1'b0; wr_s2_q <= 1'b0; wr_h_q <= 1'b0;
      rd_s1_q <= 1'b0; rd_s2_q <= 1'b0; rd_h_q <= 1'b0;
    end else begin
      wr_s1_q <= !HOST_nCS && !HOST_nWE && HOST_nOE;
      wr_s2_q <= wr_s1_q;
      wr_h_q  <= wr_s2_q;
      rd_s1_q <= !HOST_nCS && !HOST_nOE;
      rd_s2_q <= rd_s1_q;
      rd_h_q  <= rd_s2_q;
    end
  end

  assign wr_edge = wr_s2_q && !wr_h_q;
  assign rd_edge = rd_s2_q && !rd_h_q;

  // Address decode. The host holds address/data stable for the whole strobe,
  // so the raw pins are safe to use at the synchronised edge.
  logic [18:0]    waddr;
  logic [18:0]    res_off;
  logic           sel, cfg_hit, cmd_hit, stat_hit, ctrl_hit, clr_hit, res_hit;
  logic [CIW-1:0] cfg_idx;
  logic [RIW-1:0] res_idx;
  logic           unused_addr;

  assign waddr    = HOST_ADD[19:1];
  assign sel      = !HOST_ADD[ADDR_W-1];
  // Addresses below the result window wrap to huge offsets, so a single
  // unsigned compare bounds the window on both sides.
  assign res_off  = waddr - 19'h01800;
  assign cfg_hit  = sel && (waddr < 19'(NUM_CFG));
  assign cmd_hit  = sel && (waddr == 19'h00800);
  assign stat_hit = sel && (waddr == 19'h01000);
  assign ctrl_hit = sel && (waddr == 19'h01001);
  assign clr_hit  = sel && (waddr == 19'h01002);
  assign res_hit  = sel && (res_off < 19'(NUM_RES));
  assign cfg_idx  = waddr[CIW-1:0];
  assign res_idx  = res_off[RIW-1:0];
  assign unused_addr = ^HOST_ADD;

  // Register state
  logic [15:0]      cfg_q  [NUM_CFG];
  logic [15:0]      res_q  [NUM_RES];
  logic [15:0]      snap_q [NUM_RES];
  logic [15:0]      hdo_q;
  logic [CMD_W-1:0] proc_cmd_q, last_cmd_q;
  logic             irq_en_q, irq_q;
  logic             done_q, done_d, overrun_q, overrun_d;
  logic [15:0]      rd_data;

  // Flag next state: a capture in the same cycle as a clear wins.
  always_comb begin
    done_d    = done_q;
    overrun_d = overrun_q;
    if (wr_edge && clr_hit) begin
      if (HDI[8]) done_d    = 1'b0;
      if (HDI[9]) overrun_d = 1'b0;
    end
    if (res_valid) begin
      done_d = 1'b1;
      if (done_q) overrun_d = 1'b1;
    end
  end

  // Word 0 of the result window is read live while the snapshot is taken,
  // so the whole multi-word result is coherent from the host's view.
  always_comb begin
    rd_data = '0;
    if (cfg_hit)       rd_data = cfg_q[cfg_idx];
    else if (cmd_hit)  rd_data = 16'(last_cmd_q);
    else if (stat_hit) rd_data = {6'b0, overrun_q, done_q, 4'b0, proc_status};
    else if (ctrl_hit) rd_data = {15'b0, irq_en_q};
    else if (res_hit)  rd_data = (res_idx == '0) ? res_q[0] : snap_q[res_idx];
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      for (int j = 0; j < NUM_RES; j++) begin
        res_q[j]  <= '0;
        snap_q[j] <= '0;
      end
      hdo_q      <= '0;
      proc_cmd_q <= '0;
      last_cmd_q <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      irq_q      <= done_q && irq_en_q;
      proc_cmd_q <= '0;
      if (wr_edge) begin
        if (cfg_hit)  cfg_q[cfg_idx] <= HDI;
        if (ctrl_hit) irq_en_q <= HDI[0];
        if (cmd_hit) begin
          proc_cmd_q <= HDI[CMD_W-1:0];
          last_cmd_q <= HDI[CMD_W-1:0];
        end
      end
      if (rd_edge) begin
        hdo_q <= rd_data;
        if (res_hit && (res_idx == '0)) snap_q <= res_q;
      end
      if (res_valid) begin
        for (int j = 0; j < NUM_RES; j++) res_q[j] <= res_din[16*j +: 16];
      end
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg[16*g +: 16] = cfg_q[g];
  end

  assign HDO      = hdo_q;
  assign proc_cmd = proc_cmd_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_host_reg_bank.sv
`timescale 1ns/1ps
module tb_host_reg_bank;
  localparam int ADDR_W  = 21;
  localparam int NUM_CFG = 14;
  localparam int NUM_RES = 8;
  localparam int CMD_W   = 4;

  // Clock / reset and DUT signals
  logic                  clk = 1'b0;
  logic                  nRESET;
  logic                  HOST_nCS, HOST_nWE, HOST_nOE;
  logic [ADDR_W-1:0]     HOST_ADD;
  logic [15:0]           HDI;
  logic [15:0]           HDO;
  logic [NUM_CFG*16-1:0] cfg;
  logic [CMD_W-1:0]      proc_cmd;
  logic [3:0]            proc_status;
  logic [NUM_RES*16-1:0] res_din;
  logic                  res_valid;
  logic                  irq;

  always #5 clk = ~clk;

  host_reg_bank #(
    .ADDR_W(ADDR_W), .NUM_CFG(NUM_CFG), .NUM_RES(NUM_RES), .CMD_W(CMD_W)
  ) dut (
    .clk(clk), .nRESET(nRESET),
    .HOST_nCS(HOST_nCS), .HOST_nWE(HOST_nWE), .HOST_nOE(HOST_nOE),
    .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO),
    .cfg(cfg), .proc_cmd(proc_cmd), .proc_status(proc_status),
    .res_din(res_din), .res_valid(res_valid), .irq(irq)
  );

  // Scoreboard
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Driver tasks: all start and end on a falling clock edge.
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [15:0] d, input int len);
    HOST_ADD = a; HDI = d;
    HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    repeat (len) @(negedge clk);
    HOST_nCS = 1'b1; HOST_nWE = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [15:0] exp, input string nm);
    logic [15:0] e;
    exp_q.push_back(exp);
    HOST_ADD = a;
    HOST_nCS = 1'b0; HOST_nOE = 1'b0;
    repeat (5) @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: scoreboard queue empty", nm);
    end else begin
      e = exp_q.pop_front();
      check(nm, 32'(HDO), 32'(e));
    end
    HOST_nCS = 1'b1; HOST_nOE = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_res(input logic [15:0] base);
    for (int j = 0; j < NUM_RES; j++) res_din[16*j +: 16] = base + 16'(j);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]     data;   // write data, or expected read data
  } vec_t;

  vec_t vt[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cnt;
    int          first;
    logic        irq_at3, irq_at4;
    logic [15:0] e;

    vt[0]  = '{1'b1, 21'h000000, 16'h1234};
    vt[1]  = '{1'b1, 21'h00001A, 16'hABCD};
    vt[2]  = '{1'b0, 21'h000000, 16'h1234};
    vt[3]  = '{1'b0, 21'h00001A, 16'hABCD};
    vt[4]  = '{1'b0, 21'h000002, 16'h0000};
    vt[5]  = '{1'b1, 21'h100004, 16'h7777};  // other bank: dropped
    vt[6]  = '{1'b1, 21'h00002E, 16'h8888};  // word 23, past NUM_CFG: dropped
    vt[7]  = '{1'b0, 21'h000004, 16'h0000};
    vt[8]  = '{1'b0, 21'h100000, 16'h0000};  // other bank reads 0
    vt[9]  = '{1'b0, 21'h00002E, 16'h0000};
    vt[10] = '{1'b0, 21'h002004, 16'h0000};  // clear register reads 0
    vt[11] = '{1'b0, 21'h004000, 16'h0000};
    vt[12] = '{1'b0, 21'h000001, 16'h1234};  // address bit 0 ignored
    vt[13] = '{1'b1, 21'h002002, 16'h0001};
    vt[14] = '{1'b0, 21'h002002, 16'h0001};
    vt[15] = '{1'b1, 21'h002002, 16'h0000};

    nRESET = 1'b0;
    HOST_nCS = 1'b1; HOST_nWE = 1'b1; HOST_nOE = 1'b1;
    HOST_ADD = '0; HDI = '0;
    res_din = '0; res_valid = 1'b0;
    proc_status = 4'hA;
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    repeat (2) @(negedge clk);

    check("reset_hdo", 32'(HDO), 0);
    check("reset_cmd", 32'(proc_cmd), 0);
    check("reset_irq", 32'(irq), 0);
    check("reset_cfg", {31'b0, |cfg}, 0);

    // Reset in the middle of a write strobe
    host_write(21'h000000, 16'h5555, 4);
    host_read(21'h000000, 16'h5555, "pre_reset_read");
    HOST_ADD = 21'h000002; HDI = 16'h4444;
    HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    repeat (2) @(negedge clk);
    nRESET = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_hdo", 32'(HDO), 0);
    check("midreset_cfg", {31'b0, |cfg}, 0);
    check("midreset_cmd", 32'(proc_cmd), 0);
    check("midreset_irq", 32'(irq), 0);
    nRESET = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_cfg1", 32'(cfg[31:16]), 32'h4444);
    check("post_reset_cfg0", 32'(cfg[15:0]), 0);
    HOST_nCS = 1'b1; HOST_nWE = 1'b1;
    repeat (4) @(negedge clk);
    nRESET = 1'b0;
    @(negedge clk);
    nRESET = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven config / decode vectors
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) host_write(vt[i].addr, vt[i].data, 4);
      else          host_read(vt[i].addr, vt[i].data, $sformatf("vec%0d", i));
    end
    for (int i = 0; i < NUM_CFG; i++) begin
      e = (i == 0) ? 16'h1234 : (i == 13) ? 16'hABCD : 16'h0000;
      check($sformatf("cfg_word%0d", i), 32'(cfg[16*i +: 16]), 32'(e));
    end

    // Command pulse: 10-clk strobe, one pulse on the third falling edge
    cnt = 0; first = -1;
    HOST_ADD = 21'h001000; HDI = 16'h0002;
    HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (proc_cmd != '0) begin
        cnt++;
        if (first < 0) first = k;
        check("cmd_value", 32'(proc_cmd), 2);
      end
    end
    HOST_nCS = 1'b1; HOST_nWE = 1'b1;
    repeat (4) @(negedge clk);
    check("cmd_pulse_count", cnt, 1);
    check("cmd_latency", first, 3);
    host_read(21'h001000, 16'h0002, "last_cmd_read");
    host_write(21'h001000, 16'h00F5, 4);
    host_read(21'h001000, 16'h0005, "last_cmd_masked");

    // Capture and sticky flags
    pulse_res(16'h1111);
    host_read(21'h002000, 16'h010A, "status_done");
    host_read(21'h003000, 16'h1111, "result_word0");
    pulse_res(16'h2222);
    host_read(21'h002000, 16'h030A, "status_overrun");
    host_write(21'h002004, 16'h0300, 4);
    host_read(21'h002000, 16'h000A, "status_cleared");
    pulse_res(16'h3333);
    // Clear commits on the third rising edge; res_valid lands on the same edge
    HOST_ADD = 21'h002004; HDI = 16'h0300;
    HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    repeat (2) @(negedge clk);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    HOST_nCS = 1'b1; HOST_nWE = 1'b1;
    repeat (4) @(negedge clk);
    host_read(21'h002000, 16'h030A, "status_set_wins");

    // Coherent snapshot
    host_write(21'h002004, 16'h0300, 4);
    pulse_res(16'h0000);
    host_read(21'h003000, 16'h0000, "snap_word0");
    pulse_res(16'h00F0);
    host_read(21'h003002, 16'h0001, "snap_word1_old");
    host_read(21'h003004, 16'h0002, "snap_word2_old");
    host_read(21'h003000, 16'h00F0, "snap_word0_new");
    host_read(21'h003002, 16'h00F1, "snap_word1_new");
    host_read(21'h00300E, 16'h00F7, "snap_word7_new");
    host_read(21'h003010, 16'h0000, "result_past_end");

    // Interrupt
    host_write(21'h002002, 16'h0000, 4);
    host_write(21'h002004, 16'h0300, 4);
    pulse_res(16'h0100);
    repeat (4) @(negedge clk);
    check("irq_disabled", 32'(irq), 0);
    irq_at3 = 1'b1; irq_at4 = 1'b0;
    HOST_ADD = 21'h002002; HDI = 16'h0001;
    HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) irq_at3 = irq;
      if (k == 4) irq_at4 = irq;
    end
    HOST_nCS = 1'b1; HOST_nWE = 1'b1;
    repeat (4) @(negedge clk);
    check("irq_before_enable", 32'(irq_at3), 0);
    check("irq_after_enable", 32'(irq_at4), 1);
    host_write(21'h002004, 16'h0100, 4);
    check("irq_after_clear", 32'(irq), 0);
    host_read(21'h002000, 16'h000A, "status_after_irq_clear");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
